// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding, parity modes,
// and the counter width helper used by uart_rx and uart_tx.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  // Bits needed to hold values 0..n-1; never less than 1.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bundle of uart_rx: received word, status flags and the ready handshake.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DATA_BIT = 8
);
  logic [DATA_BIT-1:0] data;
  logic                valid;
  logic                ready;
  logic                parity_err;
  logic                frame_err;
  logic                overrun;

  modport master (output data, valid, parity_err, frame_err, overrun, input ready);
  modport slave  (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; 2-cycle latency,
// resets to the line's idle level so reset release never looks like a start edge.
`timescale 1ns/1ps
module uart_sync_2ff (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: word valid one cycle after the last stop sample; never stalls the line,
// a frame finishing while a word is held unaccepted is dropped with o_overrun. Option: UART_RX_MAJORITY_EN.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter string CHECK_BIT = "None",
  parameter int    BPS       = 115200,
  parameter int    CLK       = 25_000_000,
  parameter int    DATA_BIT  = 8,
  parameter int    STOP_BIT  = 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_rxd,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_parity_err,
  output logic                o_frame_err,
  output logic                o_overrun
);
  localparam int      BPS_CNT = CLK / BPS;
  localparam int      CW      = clog2w(BPS_CNT);
  localparam int      NB      = (DATA_BIT > STOP_BIT) ? DATA_BIT : STOP_BIT;
  localparam int      BW      = clog2w(NB + 1);
  localparam parity_e PMODE   = (CHECK_BIT == "Odd")  ? PAR_ODD :
                                (CHECK_BIT == "Even") ? PAR_EVEN : PAR_NONE;

  localparam logic [CW-1:0] HALF      = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] FULL      = CW'(BPS_CNT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BIT - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BIT - 1);

  logic                rxd_s;
  logic                rx_d1_q;
  logic [1:0]          fill_q;
  logic                armed_q;
  logic                bit_val;
  logic                done;
  logic                accept;

  uart_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       idx_q, idx_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_out_q, ferr_out_d;
  logic                ovr_q, ovr_d;

  uart_sync_2ff u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rxd),
    .o_q       (rxd_s)
  );

  // The decision cycle looks at rx_d1_q as the mid-bit sample so that the
  // following sample (rxd_s) is already available for the majority vote.
`ifdef UART_RX_MAJORITY_EN
  logic rx_d2_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rx_d2_q <= 1'b1;
    else            rx_d2_q <= rx_d1_q;
  end

  assign bit_val = (rx_d2_q & rx_d1_q) | (rx_d2_q & rxd_s) | (rx_d1_q & rxd_s);
`else
  assign bit_val = rx_d1_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (armed_q && rx_d1_q && !rxd_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = bit_val ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {bit_val, shift_q[DATA_BIT-1:1]};
          par_d   = par_q ^ bit_val;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PMODE == PAR_NONE) ? S_STOP : S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          perr_d  = par_q ^ bit_val ^ (PMODE == PAR_ODD);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~bit_val;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // An accept in the completion cycle frees the holding register for the new word.
  always_comb begin
    accept     = valid_q && i_ready;
    data_d     = data_q;
    valid_d    = valid_q && !accept;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    if (done) begin
      if (!valid_q || accept) begin
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_d;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_d1_q    <= 1'b1;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_d1_q    <= rxd_s;
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_q | (fill_q[1] & rxd_s);
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 25 MHz / 115200 baud: one 8N1 instance and one 8E1 instance.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BPS_CNT = 25_000_000 / 115200;

  logic clk;
  logic rst_n;
  logic rxd;
  logic rxd_e;

  int n_tests;
  int n_fail;

  uart_rx_if #(.DATA_BIT(8)) rx_if ();
  uart_rx_if #(.DATA_BIT(8)) rx_if_e ();

  uart_rx #(
    .CHECK_BIT ("None"),
    .BPS       (115200),
    .CLK       (25_000_000),
    .DATA_BIT  (8),
    .STOP_BIT  (1)
  ) u_dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rxd        (rxd),
    .o_data       (rx_if.data),
    .o_valid      (rx_if.valid),
    .i_ready      (rx_if.ready),
    .o_parity_err (rx_if.parity_err),
    .o_frame_err  (rx_if.frame_err),
    .o_overrun    (rx_if.overrun)
  );

  uart_rx #(
    .CHECK_BIT ("Even"),
    .BPS       (115200),
    .CLK       (25_000_000),
    .DATA_BIT  (8),
    .STOP_BIT  (1)
  ) u_dut_even (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rxd        (rxd_e),
    .o_data       (rx_if_e.data),
    .o_valid      (rx_if_e.valid),
    .i_ready      (rx_if_e.ready),
    .o_parity_err (rx_if_e.parity_err),
    .o_frame_err  (rx_if_e.frame_err),
    .o_overrun    (rx_if_e.overrun)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Monitors: count valid/overrun cycles and capture the last word seen valid.
  int          v_cycles, ovr_cycles, ve_cycles;
  logic [7:0]  last_data, laste_data;
  logic        last_perr, last_ferr, laste_perr, laste_ferr;

  initial begin
    v_cycles = 0; ovr_cycles = 0; ve_cycles = 0;
    last_data = '0; laste_data = '0;
    last_perr = 1'b0; last_ferr = 1'b0; laste_perr = 1'b0; laste_ferr = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_if.valid === 1'b1) begin
      v_cycles  <= v_cycles + 1;
      last_data <= rx_if.data;
      last_perr <= rx_if.parity_err;
      last_ferr <= rx_if.frame_err;
    end
    if (rx_if.overrun === 1'b1) ovr_cycles <= ovr_cycles + 1;
    if (rx_if_e.valid === 1'b1) begin
      ve_cycles  <= ve_cycles + 1;
      laste_data <= rx_if_e.data;
      laste_perr <= rx_if_e.parity_err;
      laste_ferr <= rx_if_e.frame_err;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit on_even, input logic v);
    if (on_even) rxd_e = v;
    else         rxd   = v;
    wait_cycles(BPS_CNT);
  endtask

  task automatic send_frame(input bit on_even, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    drive_bit(on_even, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(on_even, d[i]);
    if (has_par) drive_bit(on_even, par);
    drive_bit(on_even, stop);
    if (on_even) rxd_e = 1'b1;
    else         rxd   = 1'b1;
    wait_cycles(20);
  endtask

  int v0, o0, e0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    rxd     = 1'b1;
    rxd_e   = 1'b1;
    rx_if.ready   = 1'b1;
    rx_if_e.ready = 1'b1;
    wait_cycles(5);

    check_eq("rst_valid", 32'(rx_if.valid), 32'h0);
    check_eq("rst_data", 32'(rx_if.data), 32'h0);
    check_eq("rst_perr", 32'(rx_if.parity_err), 32'h0);
    check_eq("rst_ferr", 32'(rx_if.frame_err), 32'h0);
    check_eq("rst_ovr", 32'(rx_if.overrun), 32'h0);
    check_eq("rst_state", 32'(u_dut.state_q), 32'(S_IDLE));

    rst_n = 1'b1;
    wait_cycles(20);

    // 0xA5 8N1, consumer always ready
    v0 = v_cycles; o0 = ovr_cycles;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    check_eq("a5_data", 32'(last_data), 32'hA5);
    check_eq("a5_vcycles", 32'(v_cycles - v0), 32'd1);
    check_eq("a5_perr", 32'(last_perr), 32'h0);
    check_eq("a5_ferr", 32'(last_ferr), 32'h0);
    check_eq("a5_ovr", 32'(ovr_cycles - o0), 32'd0);

    // Even parity: 0x03 has two ones, parity bit 1 -> mismatch
    e0 = ve_cycles;
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    check_eq("even03_data", 32'(laste_data), 32'h03);
    check_eq("even03_perr", 32'(laste_perr), 32'h1);
    check_eq("even03_ferr", 32'(laste_ferr), 32'h0);
    check_eq("even03_vcycles", 32'(ve_cycles - e0), 32'd1);
    // 0x07 has three ones, parity bit 1 -> correct even parity
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    check_eq("even07_data", 32'(laste_data), 32'h07);
    check_eq("even07_perr", 32'(laste_perr), 32'h0);

    // Stop bit low, then a clean frame
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_eq("5a_data", 32'(last_data), 32'h5A);
    check_eq("5a_ferr", 32'(last_ferr), 32'h1);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    check_eq("11_data", 32'(last_data), 32'h11);
    check_eq("11_ferr", 32'(last_ferr), 32'h0);

    // 50-cycle glitch on an idle line
    v0 = v_cycles;
    rxd = 1'b0;
    wait_cycles(50);
    rxd = 1'b1;
    wait_cycles(400);
    check_eq("glitch_vcycles", 32'(v_cycles - v0), 32'd0);
    check_eq("glitch_state", 32'(u_dut.state_q), 32'(S_IDLE));

    // Overrun: second frame dropped while 0x12 is held
    rx_if.ready = 1'b0;
    o0 = ovr_cycles;
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
    check_eq("ovr_data_held", 32'(rx_if.data), 32'h12);
    check_eq("ovr_valid_held", 32'(rx_if.valid), 32'h1);
    check_eq("ovr_pulses", 32'(ovr_cycles - o0), 32'd1);
    rx_if.ready = 1'b1;
    wait_cycles(1);
    check_eq("ovr_accepted_data", 32'(last_data), 32'h12);
    wait_cycles(1);
    check_eq("ovr_valid_after_accept", 32'(rx_if.valid), 32'h0);

    // Reset during bit 4 of 0xE7 (bit 4 = 0, so the line stays low through reset)
    rx_if.ready = 1'b0;
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    check_eq("pre_rst_valid", 32'(rx_if.valid), 32'h1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1 ^ (i == 3));
    rxd = 1'b0;
    wait_cycles(100);
    rst_n = 1'b0;
    wait_cycles(3);
    check_eq("midrst_valid", 32'(rx_if.valid), 32'h0);
    check_eq("midrst_data", 32'(rx_if.data), 32'h0);
    check_eq("midrst_perr", 32'(rx_if.parity_err), 32'h0);
    check_eq("midrst_ferr", 32'(rx_if.frame_err), 32'h0);
    check_eq("midrst_ovr", 32'(rx_if.overrun), 32'h0);
    check_eq("midrst_state", 32'(u_dut.state_q), 32'(S_IDLE));
    v0 = v_cycles;
    rst_n = 1'b1;
    wait_cycles(500);
    check_eq("lowline_state", 32'(u_dut.state_q), 32'(S_IDLE));
    check_eq("lowline_vcycles", 32'(v_cycles - v0), 32'd0);
    rxd = 1'b1;
    wait_cycles(20);
    rx_if.ready = 1'b1;
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    check_eq("c3_data", 32'(last_data), 32'hC3);
    check_eq("c3_ferr", 32'(last_ferr), 32'h0);
    check_eq("c3_vcycles", 32'(v_cycles - v0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
